// File: rtl/card_sprite_fetch.sv
// Sprite-ROM address generator and pixel post-processor for one card pixel per request.
// Fixed latency of ROM_LAT+2 cycles, no backpressure.
module card_sprite_fetch #(
    parameter int          CARD_W          = 32,
    parameter int          CARD_H          = 46,
    parameter int          NUM_COLORS      = 4,
    parameter int          CARDS_PER_COLOR = 13,
    parameter int          ADDR_W          = 15,
    parameter int          ROM_LAT         = 1,
    parameter int          TYPE_W          = 6,
    parameter logic [11:0] KEY_COLOR       = 12'hF0F,
    parameter logic [11:0] HL_COLOR        = 12'hFF0,
    parameter logic [11:0] BACK_A          = 12'h00F,
    parameter logic [11:0] BACK_B          = 12'hFFF
) (
    input  logic                           clk_25MHz,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic [5:0]                     pixel_x,
    input  logic [5:0]                     pixel_y,
    input  logic [TYPE_W-1:0]              card_type,
    input  logic                           face_down,
    input  logic                           highlight,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [12*(NUM_COLORS+2)-1:0]   rom_dout,
    output logic                           out_valid,
    output logic [11:0]                    card_pixel,
    output logic                           transparent
);

    localparam int NC     = NUM_COLORS * CARDS_PER_COLOR;
    localparam int NBANK  = NUM_COLORS + 2;
    localparam int BANK_W = $clog2(NBANK);
    localparam int SPR_SZ = CARD_W * CARD_H;

    typedef enum logic [1:0] {
        M_ROM,
        M_BACK,
        M_OOB,
        M_INV
    } mode_e;

    typedef struct packed {
        logic              valid;
        mode_e             mode;
        logic [BANK_W-1:0] bank;
        logic [5:0]        x;
        logic [5:0]        y;
        logic              hl;
    } sb_t;

    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    sb_t               sb_d [ROM_LAT+1];
    sb_t               sb_q [ROM_LAT+1];
    logic              out_valid_d, out_valid_q;
    logic [11:0]       card_pixel_d, card_pixel_q;
    logic              transparent_d, transparent_q;

    logic [31:0] ct_w, x_w, y_w, lin;
    logic        oob;

    // Stage A: decode request into ROM address and aligned sideband
    always_comb begin
        ct_w       = 32'(card_type);
        x_w        = 32'(pixel_x);
        y_w        = 32'(pixel_y);
        lin        = y_w * CARD_W + x_w;
        oob        = (x_w >= CARD_W) || (y_w >= CARD_H);
        rom_addr_d = rom_addr_q;
        sb_d[0]    = '0;
        sb_d[0].valid = req_valid;
        sb_d[0].x     = pixel_x;
        sb_d[0].y     = pixel_y;
        sb_d[0].hl    = highlight;
        sb_d[0].mode  = M_INV;
        if (oob) begin
            sb_d[0].mode = M_OOB;
        end else if (face_down) begin
            sb_d[0].mode = M_BACK;
        end else if (ct_w < NC) begin
            sb_d[0].mode = M_ROM;
            sb_d[0].bank = BANK_W'(ct_w / CARDS_PER_COLOR);
        end else if (ct_w == NC) begin
            sb_d[0].mode = M_ROM;
            sb_d[0].bank = BANK_W'(NUM_COLORS);
        end else if (ct_w == NC + 1) begin
            sb_d[0].mode = M_ROM;
            sb_d[0].bank = BANK_W'(NUM_COLORS + 1);
        end
        if (req_valid) begin
            rom_addr_d = '0;
            if (sb_d[0].mode == M_ROM) begin
                if (ct_w < NC) begin
                    rom_addr_d = ADDR_W'((ct_w % CARDS_PER_COLOR) * SPR_SZ + lin);
                end else begin
                    rom_addr_d = ADDR_W'(lin);
                end
            end
        end
        for (int k = 1; k <= ROM_LAT; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    sb_t         s;
    logic [11:0] pix;
    logic        border;

    // Stage B: the last sideband slot lines up with rom_dout
    always_comb begin
        s      = sb_q[ROM_LAT];
        pix    = '0;
        for (int k = 0; k < NBANK; k++) begin
            if (32'(s.bank) == k) pix = rom_dout[12*k +: 12];
        end
        border = (32'(s.x) < 2) || (32'(s.y) < 2) ||
                 (32'(s.x) >= CARD_W - 2) || (32'(s.y) >= CARD_H - 2);
        out_valid_d   = s.valid;
        card_pixel_d  = card_pixel_q;
        transparent_d = transparent_q;
        if (s.valid) begin
            if (s.mode == M_OOB || s.mode == M_INV) begin
                card_pixel_d  = '0;
                transparent_d = 1'b1;
            end else if (s.hl && border) begin
                card_pixel_d  = HL_COLOR;
                transparent_d = 1'b0;
            end else if (s.mode == M_BACK) begin
                card_pixel_d  = (s.x[2] ^ s.y[2]) ? BACK_B : BACK_A;
                transparent_d = 1'b0;
            end else if (pix == KEY_COLOR) begin
                card_pixel_d  = '0;
                transparent_d = 1'b1;
            end else begin
                card_pixel_d  = pix;
                transparent_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            rom_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            card_pixel_q  <= '0;
            transparent_q <= 1'b0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            rom_addr_q    <= rom_addr_d;
            out_valid_q   <= out_valid_d;
            card_pixel_q  <= card_pixel_d;
            transparent_q <= transparent_d;
            for (int k = 0; k <= ROM_LAT; k++) begin
                sb_q[k] <= sb_d[k];
            end
        end
    end

    assign rom_addr    = rom_addr_q;
    assign out_valid   = out_valid_q;
    assign card_pixel  = card_pixel_q;
    assign transparent = transparent_q;

endmodule

// File: tb/tb_card_sprite_fetch.sv
// Directed and random bench for card_sprite_fetch with ROM latency 1 and 3.
// Both instances share stimulus; each has its own latency-matched ROM model.
module tb_card_sprite_fetch;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst, req_valid, face_down, highlight;
    logic [5:0]  pixel_x, pixel_y, card_type;
    logic [14:0] rom_addr1, rom_addr3;
    logic [71:0] rom_dout1, rom_dout3;
    logic        ov1, ov3, tr1, tr3;
    logic [11:0] px1, px3;

    card_sprite_fetch #(.ROM_LAT(1)) u_l1 (
        .clk_25MHz(clk), .rst(rst), .req_valid(req_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .card_type(card_type),
        .face_down(face_down), .highlight(highlight),
        .rom_addr(rom_addr1), .rom_dout(rom_dout1),
        .out_valid(ov1), .card_pixel(px1), .transparent(tr1)
    );

    card_sprite_fetch #(.ROM_LAT(3)) u_l3 (
        .clk_25MHz(clk), .rst(rst), .req_valid(req_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .card_type(card_type),
        .face_down(face_down), .highlight(highlight),
        .rom_addr(rom_addr3), .rom_dout(rom_dout3),
        .out_valid(ov3), .card_pixel(px3), .transparent(tr3)
    );

    function automatic logic [11:0] rom_fn(input int bank, input logic [14:0] a);
        return a[11:0] ^ (12'(bank) << 8);
    endfunction

    logic [14:0] a1_q;
    logic [14:0] a3_q [3];
    always @(posedge clk) begin
        a1_q    <= rom_addr1;
        a3_q[0] <= rom_addr3;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end

    always_comb begin
        rom_dout1 = '0;
        rom_dout3 = '0;
        for (int k = 0; k < 6; k++) begin
            rom_dout1[12*k +: 12] = rom_fn(k, a1_q);
            rom_dout3[12*k +: 12] = rom_fn(k, a3_q[2]);
        end
    end

    typedef struct {
        int          due;
        logic [11:0] pix;
        logic        tr;
    } exp_t;

    typedef struct {
        logic [5:0]  ct;
        logic [5:0]  x;
        logic [5:0]  y;
        logic        fd;
        logic        hl;
        logic [14:0] addr;
        logic [11:0] pix;
        logic        tr;
    } vec_t;

    exp_t q1[$];
    exp_t q3[$];
    vec_t tbl [18];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit in_rst   = 1'b1;

    logic [11:0] last_px1, last_px3;
    logic        last_tr1, last_tr3;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t model(input logic [5:0] ct, input logic [5:0] x,
                                   input logic [5:0] y, input logic fd, input logic hl);
        vec_t v;
        int   ict, ix, iy, bank, mode;
        ict = int'(ct);
        ix  = int'(x);
        iy  = int'(y);
        v.ct = ct; v.x = x; v.y = y; v.fd = fd; v.hl = hl;
        bank = 0;
        v.addr = '0;
        // mode: 0 rom, 1 back, 2 oob, 3 invalid
        if (ix >= 32 || iy >= 46) mode = 2;
        else if (fd) mode = 1;
        else if (ict < 52) begin
            mode = 0;
            bank = ict / 13;
            v.addr = 15'((ict % 13) * 1472 + iy * 32 + ix);
        end else if (ict == 52 || ict == 53) begin
            mode = 0;
            bank = ict - 48;
            v.addr = 15'(iy * 32 + ix);
        end else mode = 3;
        if (mode >= 2) begin
            v.pix = 12'h000; v.tr = 1'b1;
        end else if (hl && (ix < 2 || iy < 2 || ix >= 30 || iy >= 44)) begin
            v.pix = 12'hFF0; v.tr = 1'b0;
        end else if (mode == 1) begin
            v.pix = (x[2] ^ y[2]) ? 12'hFFF : 12'h00F; v.tr = 1'b0;
        end else if (rom_fn(bank, v.addr) == 12'hF0F) begin
            v.pix = 12'h000; v.tr = 1'b1;
        end else begin
            v.pix = rom_fn(bank, v.addr); v.tr = 1'b0;
        end
        return v;
    endfunction

    task automatic chk_out(input string nm, input bit d, input exp_t e,
                           input logic ov, input logic [11:0] px, input logic tr,
                           input logic [11:0] lp, input logic lt);
        n_checks++;
        if (d) begin
            if (ov !== 1'b1 || px !== e.pix || tr !== e.tr) begin
                n_fail++;
                $display("FAIL %s result: valid=%b pixel=%h transp=%b, required valid=1 pixel=%h transp=%b (cycle %0d)",
                         nm, ov, px, tr, e.pix, e.tr, cyc);
            end
        end else if (ov !== 1'b0 || px !== lp || tr !== lt) begin
            n_fail++;
            $display("FAIL %s idle/hold: valid=%b pixel=%h transp=%b, required valid=0 pixel=%h transp=%b (cycle %0d)",
                     nm, ov, px, tr, lp, lt, cyc);
        end
    endtask

    bit   d1, d3;
    exp_t e1, e3;
    always @(negedge clk) begin
        if (!in_rst) begin
            d1 = (q1.size() > 0) && (q1[0].due == cyc);
            d3 = (q3.size() > 0) && (q3[0].due == cyc);
            e1 = '{due: 0, pix: 12'h0, tr: 1'b0};
            e3 = '{due: 0, pix: 12'h0, tr: 1'b0};
            if (d1) e1 = q1.pop_front();
            if (d3) e3 = q3.pop_front();
            chk_out("lat1", d1, e1, ov1, px1, tr1, last_px1, last_tr1);
            chk_out("lat3", d3, e3, ov3, px3, tr3, last_px3, last_tr3);
            last_px1 = px1; last_tr1 = tr1;
            last_px3 = px3; last_tr3 = tr3;
        end
    end

    task automatic issue(input vec_t v);
        card_type = v.ct;
        pixel_x   = v.x;
        pixel_y   = v.y;
        face_down = v.fd;
        highlight = v.hl;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rom_addr1 !== v.addr || rom_addr3 !== v.addr) begin
            n_fail++;
            $display("FAIL rom_addr ct=%0d x=%0d y=%0d: got %0d/%0d, required %0d",
                     v.ct, v.x, v.y, rom_addr1, rom_addr3, v.addr);
        end
        q1.push_back('{due: cyc + 2, pix: v.pix, tr: v.tr});
        q3.push_back('{due: cyc + 4, pix: v.pix, tr: v.tr});
    endtask

    task automatic check_zero(input string nm);
        n_checks++;
        if (ov1 !== 1'b0 || px1 !== 12'h0 || tr1 !== 1'b0 || rom_addr1 !== 15'h0 ||
            ov3 !== 1'b0 || px3 !== 12'h0 || tr3 !== 1'b0 || rom_addr3 !== 15'h0) begin
            n_fail++;
            $display("FAIL %s: l1 v=%b p=%h t=%b a=%0d l3 v=%b p=%h t=%b a=%0d, required all 0",
                     nm, ov1, px1, tr1, rom_addr1, ov3, px3, tr3, rom_addr3);
        end
    endtask

    task automatic do_reset(input string nm);
        rst       = 1'b1;
        in_rst    = 1'b1;
        req_valid = 1'b0;
        q1.delete();
        q3.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero(nm);
        end
        rst      = 1'b0;
        last_px1 = '0; last_tr1 = 1'b0;
        last_px3 = '0; last_tr3 = 1'b0;
        in_rst   = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [5:0] rct, rx, ry;
        logic       rfd, rhl;
        //           ct     x      y      fd    hl    addr       pix       tr
        tbl[0]  = '{6'd15, 6'd3,  6'd5,  1'b0, 1'b0, 15'd3107,  12'hD23,  1'b0};
        tbl[1]  = '{6'd51, 6'd0,  6'd0,  1'b0, 1'b0, 15'd17664, 12'h600,  1'b0};
        tbl[2]  = '{6'd52, 6'd10, 6'd2,  1'b0, 1'b0, 15'd74,    12'h44A,  1'b0};
        tbl[3]  = '{6'd53, 6'd10, 6'd2,  1'b0, 1'b0, 15'd74,    12'h54A,  1'b0};
        tbl[4]  = '{6'd60, 6'd10, 6'd2,  1'b0, 1'b0, 15'd0,     12'h000,  1'b1};
        tbl[5]  = '{6'd5,  6'd32, 6'd0,  1'b0, 1'b1, 15'd0,     12'h000,  1'b1};
        tbl[6]  = '{6'd2,  6'd15, 6'd28, 1'b0, 1'b0, 15'd3855,  12'h000,  1'b1};
        tbl[7]  = '{6'd0,  6'd1,  6'd20, 1'b0, 1'b1, 15'd641,   12'hFF0,  1'b0};
        tbl[8]  = '{6'd0,  6'd4,  6'd0,  1'b1, 1'b0, 15'd0,     12'hFFF,  1'b0};
        tbl[9]  = '{6'd0,  6'd4,  6'd4,  1'b1, 1'b0, 15'd0,     12'h00F,  1'b0};
        tbl[10] = '{6'd0,  6'd31, 6'd45, 1'b0, 1'b0, 15'd1471,  12'h5BF,  1'b0};
        tbl[11] = '{6'd0,  6'd0,  6'd46, 1'b0, 1'b0, 15'd0,     12'h000,  1'b1};
        tbl[12] = '{6'd53, 6'd30, 6'd10, 1'b0, 1'b1, 15'd350,   12'hFF0,  1'b0};
        tbl[13] = '{6'd3,  6'd0,  6'd10, 1'b1, 1'b1, 15'd0,     12'hFF0,  1'b0};
        tbl[14] = '{6'd3,  6'd5,  6'd10, 1'b1, 1'b0, 15'd0,     12'hFFF,  1'b0};
        tbl[15] = '{6'd12, 6'd7,  6'd3,  1'b0, 1'b0, 15'd17767, 12'h567,  1'b0};
        tbl[16] = '{6'd25, 6'd2,  6'd2,  1'b0, 1'b1, 15'd17730, 12'h442,  1'b0};
        tbl[17] = '{6'd39, 6'd31, 6'd0,  1'b0, 1'b0, 15'd31,    12'h31F,  1'b0};

        rst = 1'b1; req_valid = 1'b0; face_down = 1'b0; highlight = 1'b0;
        pixel_x = '0; pixel_y = '0; card_type = '0;
        #1;
        do_reset("reset state");

        for (int i = 0; i < 18; i++) issue(tbl[i]);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rom_addr1 !== 15'd31 || rom_addr3 !== 15'd31) begin
            n_fail++;
            $display("FAIL rom_addr hold: got %0d/%0d, required 31", rom_addr1, rom_addr3);
        end
        repeat (8) @(posedge clk);
        #1;

        issue(tbl[0]);
        issue(tbl[1]);
        do_reset("mid-stream reset");
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            rct = 6'($urandom_range(0, 63));
            rx  = 6'($urandom_range(0, 35));
            ry  = 6'($urandom_range(0, 49));
            rhl = 1'($urandom_range(0, 1));
            rfd = (rct <= 6'd53) ? ($urandom_range(0, 3) == 0) : 1'b0;
            v = model(rct, rx, ry, rfd, rhl);
            issue(v);
        end
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        n_checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d results outstanding, required 0", q1.size(), q3.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
